// File: rtl/lb_pkg.sv
// ============================================================
// Package : lb_pkg
// Brief   : Shared geometry defaults and pixel type for the line-buffer window.
// Rev     : 1.0
// ============================================================
`default_nettype none

package lb_pkg;
    localparam int PIX_W = 7;
    localparam int K     = 9;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int WIN_N = K * K;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    typedef logic [PIX_W-1:0] pix_t;
endpackage

`default_nettype wire

// File: rtl/lb_line_mem.sv
// ============================================================
// Module : lb_line_mem
// Brief  : One image line of pixel storage; combinational read, write at same col.
// Rev    : 1.0
// ============================================================
`default_nettype none

module lb_line_mem #(
    parameter int PIX_W = lb_pkg::PIX_W,
    parameter int IMG_W = lb_pkg::IMG_W
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(IMG_W)-1:0]   addr,
    input  logic [PIX_W-1:0]           wdata,
    output logic [PIX_W-1:0]           rdata
);
    import lb_pkg::*;

    logic [PIX_W-1:0] mem [IMG_W];

    // Read sees the old contents; the write lands at the clock edge.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

`default_nettype wire

// File: rtl/linebuffer_window.sv
// ============================================================
// Module : linebuffer_window
// Brief  : KxK sliding window generator over a row-major pixel stream.
//          Define LINEBUFFER_WIN_COUNT_EN to add win_count / frame_done.
// Rev    : 1.0
// ============================================================
`default_nettype none

module linebuffer_window #(
    parameter int PIX_W = lb_pkg::PIX_W,
    parameter int K     = lb_pkg::K,
    parameter int IMG_W = lb_pkg::IMG_W,
    parameter int IMG_H = lb_pkg::IMG_H
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [PIX_W-1:0]        in_pix,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [K*K*PIX_W-1:0]    win_data
`ifdef LINEBUFFER_WIN_COUNT_EN
    ,
    output logic [15:0]             win_count,
    output logic                    frame_done
`endif
);
    import lb_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]    col, cur_col, nxt_col;
    logic [RW-1:0]    row, cur_row, nxt_row;
    logic             accept, consume, emit;
    logic [PIX_W-1:0] win     [K][K];
    logic [PIX_W-1:0] tap     [K];
    logic [PIX_W-1:0] line_rd [K-1];

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = win_valid && win_ready;

    // in_sof overrides the counters so a resync pixel is always treated as (0,0).
    always_comb begin
        cur_col = in_sof ? '0 : col;
        cur_row = in_sof ? '0 : row;
        emit    = (cur_row >= RW'(K-1)) && (cur_col >= CW'(K-1));
        nxt_col = cur_col + 1'b1;
        nxt_row = cur_row;
        if (cur_col == CW'(IMG_W-1)) begin
            nxt_col = '0;
            nxt_row = (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + 1'b1;
        end
    end

    // Line 0 holds the previous line; each accept pushes the column up one line.
    for (genvar j = 0; j < K-1; j++) begin : g_line
        if (j == 0) begin : g_head
            lb_line_mem #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_line (
                .clk   (clk),
                .we    (accept),
                .addr  (cur_col),
                .wdata (in_pix),
                .rdata (line_rd[j])
            );
        end else begin : g_tail
            lb_line_mem #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_line (
                .clk   (clk),
                .we    (accept),
                .addr  (cur_col),
                .wdata (line_rd[j-1]),
                .rdata (line_rd[j])
            );
        end
    end

    for (genvar r = 0; r < K-1; r++) begin : g_tap
        assign tap[r] = line_rd[K-2-r];
    end
    assign tap[K-1] = in_pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K-1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][K-1] <= tap[r];
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_out_row
        for (genvar c = 0; c < K; c++) begin : g_out_col
            assign win_data[(r*K+c)*PIX_W +: PIX_W] = win[r][c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
        end else begin
            if (accept) begin
                col       <= nxt_col;
                row       <= nxt_row;
                win_valid <= emit;
            end else if (consume) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifdef LINEBUFFER_WIN_COUNT_EN
    logic win_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_last   <= 1'b0;
            win_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (accept) begin
                win_last <= emit && (cur_row == RW'(IMG_H-1)) && (cur_col == CW'(IMG_W-1));
            end
            if (accept && in_sof) begin
                win_count <= '0;
            end else if (consume) begin
                win_count <= win_count + 1'b1;
            end
            frame_done <= consume && win_last;
        end
    end
`endif
endmodule

`default_nettype wire
